// File: rtl/xgmii_tlp_arbiter.sv
// ----------------------------------------------------------------------------
// xgmii_tlp_arbiter
//
// Purpose:
//    Shares one PCIe TLP transmit path between two XGMII-RX TLP FIFOs.
//    Each FIFO presents a 72-bit first-word-fall-through head word:
//       [63:0] data, [64] valid TLP word, [65] TLP last,
//       [66] low DW enable, [67] high DW enable.
//    One channel is granted per whole TLP. Inter-frame gap words (bit 64 = 0)
//    are discarded. Beats leave through a single registered output stage with
//    valid/ready flow control. Truncated, stalled or overlong TLPs are closed
//    with an error beat so downstream can discard them.
//
// Ports:
//    clk, sys_rst            clock, asynchronous active-high reset
//    chN_dout / chN_empty    FIFO head word and empty flag (N = 0, 1)
//    chN_rd_en               combinational pop strobe for FIFO N
//    tx_data/be/valid/last   outgoing beat, be = {hi DW en, lo DW en}
//    tx_err                  with tx_last: the TLP was aborted
//    tx_src                  channel that sourced the beat
//    tx_ready                downstream accepts when tx_valid & tx_ready
//    tlp_count0/1            completed TLPs per channel (wrapping)
//    err_count               aborted TLPs (saturating)
// ----------------------------------------------------------------------------
module xgmii_tlp_arbiter #(
   parameter bit RR_EN         = 1'b1,
   parameter int MAX_TLP_BEATS = 130,
   parameter int STALL_LIMIT   = 255
) (
   input  logic        clk,
   input  logic        sys_rst,
   input  logic [71:0] ch0_dout,
   input  logic        ch0_empty,
   output logic        ch0_rd_en,
   input  logic [71:0] ch1_dout,
   input  logic        ch1_empty,
   output logic        ch1_rd_en,
   output logic [63:0] tx_data,
   output logic [1:0]  tx_be,
   output logic        tx_valid,
   output logic        tx_last,
   output logic        tx_err,
   output logic        tx_src,
   input  logic        tx_ready,
   output logic [7:0]  tlp_count0,
   output logic [7:0]  tlp_count1,
   output logic [7:0]  err_count
);

   localparam logic [7:0] MaxBeats = 8'(MAX_TLP_BEATS);
   localparam logic [7:0] StallLim = 8'(STALL_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        lastGrant_q, lastGrant_d;
   logic [7:0]  beatCnt_q, beatCnt_d;
   logic [7:0]  stallCnt_q, stallCnt_d;
   logic [63:0] txData_q, txData_d;
   logic [1:0]  txBe_q, txBe_d;
   logic        txValid_q, txValid_d;
   logic        txLast_q, txLast_d;
   logic        txErr_q, txErr_d;
   logic        txSrc_q, txSrc_d;
   logic [7:0]  tlpCount0_q, tlpCount0_d;
   logic [7:0]  tlpCount1_q, tlpCount1_d;
   logic [7:0]  errCount_q, errCount_d;

   logic        space;
   logic [71:0] headW;
   logic        headEmpty;
   logic        req0, req1;
   logic        pick;
   logic        pop0, pop1;
   logic        popG;
   logic [7:0]  nextBeat;
   logic [7:0]  errInc;

   // Next-state logic. The output register can take a new beat whenever it is
   // empty or its current beat is being accepted; every pop that produces a
   // beat and every abort beat waits for that space. Gap discards in IDLE and
   // pops in DRAIN produce nothing, so they never wait for space. Only the
   // granted channel is looked at outside IDLE.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      beatCnt_d   = beatCnt_q;
      stallCnt_d  = stallCnt_q;
      txData_d    = txData_q;
      txBe_d      = txBe_q;
      txValid_d   = txValid_q;
      txLast_d    = txLast_q;
      txErr_d     = txErr_q;
      txSrc_d     = txSrc_q;
      tlpCount0_d = tlpCount0_q;
      tlpCount1_d = tlpCount1_q;
      errCount_d  = errCount_q;
      pop0        = 1'b0;
      pop1        = 1'b0;
      popG        = 1'b0;
      pick        = 1'b0;

      space     = ~txValid_q | tx_ready;
      headW     = grant_q ? ch1_dout : ch0_dout;
      headEmpty = grant_q ? ch1_empty : ch0_empty;
      req0      = ~ch0_empty & ch0_dout[64];
      req1      = ~ch1_empty & ch1_dout[64];
      nextBeat  = beatCnt_q + 8'd1;
      errInc    = (errCount_q == 8'hff) ? 8'hff : errCount_q + 8'd1;

      if (space) begin
         txValid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            pop0 = ~ch0_empty & ~ch0_dout[64];
            pop1 = ~ch1_empty & ~ch1_dout[64];
            if (req0 || req1) begin
               if (req0 && req1) begin
                  pick = RR_EN ? ~lastGrant_q : 1'b0;
               end else begin
                  pick = req1;
               end
               grant_d    = pick;
               beatCnt_d  = 8'd0;
               stallCnt_d = 8'd0;
               state_d    = GRANT;
            end
         end

         GRANT: begin
            if (headEmpty) begin
               if (stallCnt_q >= StallLim) begin
                  if (space) begin
                     txValid_d  = 1'b1;
                     txData_d   = 64'd0;
                     txBe_d     = 2'b00;
                     txLast_d   = 1'b1;
                     txErr_d    = 1'b1;
                     txSrc_d    = grant_q;
                     errCount_d = errInc;
                     state_d    = IDLE;
                  end
               end else begin
                  stallCnt_d = stallCnt_q + 8'd1;
               end
            end else if (space) begin
               popG       = 1'b1;
               stallCnt_d = 8'd0;
               txValid_d  = 1'b1;
               txSrc_d    = grant_q;
               if (headW[64]) begin
                  txData_d  = headW[63:0];
                  txBe_d    = {headW[67], headW[66]};
                  txLast_d  = headW[65];
                  txErr_d   = 1'b0;
                  beatCnt_d = nextBeat;
                  if (headW[65]) begin
                     if (grant_q) begin
                        tlpCount1_d = tlpCount1_q + 8'd1;
                     end else begin
                        tlpCount0_d = tlpCount0_q + 8'd1;
                     end
                     lastGrant_d = grant_q;
                     state_d     = IDLE;
                  end else if (nextBeat == MaxBeats) begin
                     txLast_d   = 1'b1;
                     txErr_d    = 1'b1;
                     errCount_d = errInc;
                     state_d    = DRAIN;
                  end
               end else begin
                  // Gap word inside a TLP: the frame was truncated upstream.
                  txData_d   = 64'd0;
                  txBe_d     = 2'b00;
                  txLast_d   = 1'b1;
                  txErr_d    = 1'b1;
                  errCount_d = errInc;
                  state_d    = IDLE;
               end
            end
         end

         DRAIN: begin
            if (!headEmpty) begin
               popG = 1'b1;
               if (!headW[64] || headW[65]) begin
                  lastGrant_d = grant_q;
                  state_d     = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      pop0 = pop0 | (popG & ~grant_q);
      pop1 = pop1 | (popG & grant_q);
   end

   // Pops reach the FIFOs combinationally; they are masked during reset
   // because the FIFOs are being cleared by the same reset.
   assign ch0_rd_en = pop0 & ~sys_rst;
   assign ch1_rd_en = pop1 & ~sys_rst;

   // State and output registers. last_grant starts at 1 so ch0 wins the first
   // contested arbitration.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         lastGrant_q <= 1'b1;
         beatCnt_q   <= 8'd0;
         stallCnt_q  <= 8'd0;
         txData_q    <= 64'd0;
         txBe_q      <= 2'b00;
         txValid_q   <= 1'b0;
         txLast_q    <= 1'b0;
         txErr_q     <= 1'b0;
         txSrc_q     <= 1'b0;
         tlpCount0_q <= 8'd0;
         tlpCount1_q <= 8'd0;
         errCount_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         beatCnt_q   <= beatCnt_d;
         stallCnt_q  <= stallCnt_d;
         txData_q    <= txData_d;
         txBe_q      <= txBe_d;
         txValid_q   <= txValid_d;
         txLast_q    <= txLast_d;
         txErr_q     <= txErr_d;
         txSrc_q     <= txSrc_d;
         tlpCount0_q <= tlpCount0_d;
         tlpCount1_q <= tlpCount1_d;
         errCount_q  <= errCount_d;
      end
   end

   assign tx_data    = txData_q;
   assign tx_be      = txBe_q;
   assign tx_valid   = txValid_q;
   assign tx_last    = txLast_q;
   assign tx_err     = txErr_q;
   assign tx_src     = txSrc_q;
   assign tlp_count0 = tlpCount0_q;
   assign tlp_count1 = tlpCount1_q;
   assign err_count  = errCount_q;

endmodule

// File: tb/tb_xgmii_tlp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_xgmii_tlp_arbiter
//
// Two FIFO models feed the arbiter from pending word lists. Each word handed
// to a channel is also walked through a per-channel reference model that
// turns the word stream into the beats that channel must produce; those go
// into per-channel expected queues. A monitor pops the queue selected by
// tx_src for every accepted beat.
// ----------------------------------------------------------------------------
module tb_xgmii_tlp_arbiter;

   localparam int MAX_BEATS  = 130;
   localparam int STALL_LIM  = 255;
   localparam int LONG_STALL = 400;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  be;
      logic        last;
      logic        err;
   } beat_t;

   typedef struct {
      logic [71:0] w;
      int          d;
   } pend_t;

   logic        clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [71:0] ch0_dout = '1;
   logic        ch0_empty = 1'b1;
   logic        ch0_rd_en;
   logic [71:0] ch1_dout = '1;
   logic        ch1_empty = 1'b1;
   logic        ch1_rd_en;
   logic [63:0] tx_data;
   logic [1:0]  tx_be;
   logic        tx_valid;
   logic        tx_last;
   logic        tx_err;
   logic        tx_src;
   logic        tx_ready = 1'b0;
   logic [7:0]  tlp_count0;
   logic [7:0]  tlp_count1;
   logic [7:0]  err_count;

   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          rdyMode = 0;
   bit          flushReq = 1'b0;

   logic [71:0] q0[$];
   logic [71:0] q1[$];
   pend_t       pend0[$];
   pend_t       pend1[$];
   pend_t       stage[$];
   beat_t       exp0[$];
   beat_t       exp1[$];
   logic [1:0]  srcLog[$];

   int          mTlp[2];
   int          mErr;
   bit          mInTlp[2];
   bit          mDrain[2];
   int          mBeats[2];

   xgmii_tlp_arbiter dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .ch0_dout   (ch0_dout),
      .ch0_empty  (ch0_empty),
      .ch0_rd_en  (ch0_rd_en),
      .ch1_dout   (ch1_dout),
      .ch1_empty  (ch1_empty),
      .ch1_rd_en  (ch1_rd_en),
      .tx_data    (tx_data),
      .tx_be      (tx_be),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_err     (tx_err),
      .tx_src     (tx_src),
      .tx_ready   (tx_ready),
      .tlp_count0 (tlp_count0),
      .tlp_count1 (tlp_count1),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: what one channel's word stream must turn into.
   function automatic void pushExp(input int c, input beat_t b);
      if (c == 0) exp0.push_back(b);
      else exp1.push_back(b);
   endfunction

   function automatic void modelWord(input int c, input logic [71:0] w, input int d);
      beat_t ab;
      ab = '{data: 64'd0, be: 2'b00, last: 1'b1, err: 1'b1};
      if (mInTlp[c] && d > STALL_LIM) begin
         pushExp(c, ab);
         mErr++;
         mInTlp[c] = 1'b0;
      end
      if (mDrain[c]) begin
         if (!w[64] || w[65]) mDrain[c] = 1'b0;
         return;
      end
      if (!mInTlp[c]) begin
         if (!w[64]) return;
         mInTlp[c] = 1'b1;
         mBeats[c] = 0;
      end
      if (!w[64]) begin
         pushExp(c, ab);
         mErr++;
         mInTlp[c] = 1'b0;
         return;
      end
      mBeats[c]++;
      if (w[65]) begin
         pushExp(c, '{data: w[63:0], be: {w[67], w[66]}, last: 1'b1, err: 1'b0});
         mTlp[c]++;
         mInTlp[c] = 1'b0;
      end else if (mBeats[c] == MAX_BEATS) begin
         pushExp(c, '{data: w[63:0], be: {w[67], w[66]}, last: 1'b1, err: 1'b1});
         mErr++;
         mInTlp[c] = 1'b0;
         mDrain[c] = 1'b1;
      end else begin
         pushExp(c, '{data: w[63:0], be: {w[67], w[66]}, last: 1'b0, err: 1'b0});
      end
   endfunction

   task automatic stageWord(input logic [3:0] ctl, input int d);
      pend_t p;
      p.w = {4'b0000, ctl, $urandom, $urandom};
      p.d = d;
      stage.push_back(p);
   endtask

   task automatic applyStimulus(input int ch);
      foreach (stage[i]) begin
         modelWord(ch, stage[i].w, stage[i].d);
         if (ch == 0) pend0.push_back(stage[i]);
         else pend1.push_back(stage[i]);
      end
      stage.delete();
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic checkCounters();
      checkOutput("tlp_count0", 64'(tlp_count0), 64'(mTlp[0] % 256));
      checkOutput("tlp_count1", 64'(tlp_count1), 64'(mTlp[1] % 256));
      checkOutput("err_count", 64'(err_count), 64'((mErr > 255) ? 255 : mErr));
   endtask

   task automatic waitDrain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = (pend0.size() == 0) && (pend1.size() == 0) && (q0.size() == 0) &&
                (q1.size() == 0) && (exp0.size() == 0) && (exp1.size() == 0) && !tx_valid;
      end
      compared++;
      if (!done) begin
         mismatched++;
         $display("[TB] FAIL drain_timeout: got exp0=%0d exp1=%0d q0=%0d q1=%0d left, expected all empty",
                  exp0.size(), exp1.size(), q0.size(), q1.size());
      end
      repeat (2) @(negedge clk);
   endtask

   // FIFO models: pops sampled mid-cycle take effect at the next edge; a
   // pending word with a delay waits that many empty cycles before arriving.
   always begin
      bit p0, p1;
      @(negedge clk);
      p0 = ch0_rd_en;
      p1 = ch1_rd_en;
      if (p0) checkOutput("rd_en0_nonempty", 64'(q0.size() != 0), 64'd1);
      if (p1) checkOutput("rd_en1_nonempty", 64'(q1.size() != 0), 64'd1);
      @(posedge clk);
      cyc++;
      #1;
      if (flushReq) begin
         q0.delete();
         q1.delete();
         pend0.delete();
         pend1.delete();
      end else begin
         if (p0 && q0.size() != 0) void'(q0.pop_front());
         if (p1 && q1.size() != 0) void'(q1.pop_front());
         if (pend0.size() != 0) begin
            if (pend0[0].d == 0) begin
               q0.push_back(pend0[0].w);
               void'(pend0.pop_front());
            end else if (q0.size() == 0) begin
               pend0[0].d = pend0[0].d - 1;
            end
         end
         if (pend1.size() != 0) begin
            if (pend1[0].d == 0) begin
               q1.push_back(pend1[0].w);
               void'(pend1.pop_front());
            end else if (q1.size() == 0) begin
               pend1[0].d = pend1[0].d - 1;
            end
         end
      end
      ch0_empty = (q0.size() == 0);
      ch0_dout  = ch0_empty ? '1 : q0[0];
      ch1_empty = (q1.size() == 0);
      ch1_dout  = ch1_empty ? '1 : q1[0];
      tx_ready  = (rdyMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
   end

   // Monitor: every accepted beat is checked against its channel's queue.
   always begin
      beat_t got, req;
      bit    inTlp;
      logic  curSrc;
      @(negedge clk);
      if (!sys_rst && tx_valid && tx_ready) begin
         got = '{data: tx_data, be: tx_be, last: tx_last, err: tx_err};
         compared++;
         if ((tx_src ? exp1.size() : exp0.size()) == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_beat: got src=%0d beat=%0h expected no beat", tx_src, got);
         end else begin
            req = tx_src ? exp1.pop_front() : exp0.pop_front();
            if (got !== req) begin
               mismatched++;
               $display("[TB] FAIL beat_src%0d: got %0h expected %0h", tx_src, got, req);
            end
         end
         if (inTlp) checkOutput("no_interleave", 64'(tx_src), 64'(curSrc));
         curSrc = tx_src;
         inTlp  = !tx_last;
         if (tx_last) srcLog.push_back({tx_src, tx_err});
      end
   end

   initial begin
      int base, t0, t1, c, len, ngap;
      bit trunc;
      logic [1:0] req;

      // Reset state
      rdyMode = 0;
      repeat (3) @(negedge clk);
      checkOutput("rst_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("rst_tx_last", 64'(tx_last), 64'd0);
      checkOutput("rst_tx_data", tx_data, 64'd0);
      checkOutput("rst_rd_en", 64'({ch1_rd_en, ch0_rd_en}), 64'd0);
      checkCounters();
      #2 sys_rst = 1'b0;

      // Round robin with both channels continuously loaded
      base = srcLog.size();
      for (int k = 0; k < 4; k++) begin
         stageWord(4'b1101, 0);
         stageWord(4'b1111, 0);
         applyStimulus(0);
         stageWord(4'b1101, 0);
         stageWord(4'b1111, 0);
         applyStimulus(1);
      end
      waitDrain(200);
      for (int i = 0; i < 8; i++) begin
         req = {1'(i % 2), 1'b0};
         if (srcLog.size() > base + i) checkOutput("rr_order", 64'(srcLog[base + i]), 64'(req));
         else checkOutput("rr_log_len", 64'(srcLog.size()), 64'(base + 8));
      end
      checkCounters();

      // Single 3-beat TLP and first-beat latency
      stageWord(4'b1101, 0);
      stageWord(4'b1101, 0);
      stageWord(4'b1111, 0);
      applyStimulus(0);
      t0 = -1;
      t1 = -1;
      for (int i = 0; i < 20 && t0 < 0; i++) begin
         @(negedge clk);
         if (!ch0_empty) t0 = cyc;
      end
      for (int i = 0; i < 20 && t1 < 0; i++) begin
         @(negedge clk);
         if (tx_valid) t1 = cyc;
      end
      checkOutput("first_beat_latency", 64'(t1 - t0), 64'd2);
      waitDrain(100);
      checkCounters();

      // Gap words ahead of a TLP ending with low DW only
      rdyMode = 1;
      for (int i = 0; i < 4; i++) begin
         stage.push_back('{w: 72'h0, d: 0});
      end
      stageWord(4'b1101, 0);
      stageWord(4'b1101, 1);
      stageWord(4'b0111, 0);
      applyStimulus(1);
      waitDrain(200);
      checkCounters();

      // Mid-TLP stall on ch0 while ch1 waits
      base = srcLog.size();
      stageWord(4'b1101, 0);
      stageWord(4'b1101, LONG_STALL);
      stageWord(4'b1111, 0);
      applyStimulus(0);
      stageWord(4'b1101, 3);
      stageWord(4'b1111, 0);
      applyStimulus(1);
      waitDrain(1500);
      if (srcLog.size() >= base + 2) begin
         checkOutput("stall_abort_src", 64'(srcLog[base]), 64'(2'b01));
         checkOutput("after_abort_src", 64'(srcLog[base + 1]), 64'(2'b10));
      end else begin
         checkOutput("stall_log_len", 64'(srcLog.size()), 64'(base + 2));
      end
      checkCounters();

      // Overlong TLP: error on the limit beat, remainder drained silently
      for (int i = 0; i < 200; i++) stageWord(4'b1101, 0);
      stageWord(4'b1111, 0);
      applyStimulus(0);
      waitDrain(3000);
      checkCounters();

      // Randomized traffic on both channels
      for (int i = 0; i < 40; i++) begin
         c    = $urandom_range(0, 1);
         ngap = $urandom_range(0, 2);
         for (int g = 0; g < ngap; g++) stageWord({2'($urandom_range(0, 3)), 2'b00}, $urandom_range(0, 3));
         len   = $urandom_range(1, 6);
         trunc = (len > 1) && ($urandom_range(0, 9) == 0);
         for (int b = 0; b < len; b++) begin
            if (trunc && b == len - 1) stageWord({2'($urandom_range(0, 3)), 2'b00}, $urandom_range(0, 3));
            else stageWord({2'($urandom_range(0, 3)), (b == len - 1), 1'b1}, $urandom_range(0, 3));
         end
         applyStimulus(c);
      end
      waitDrain(6000);
      checkCounters();

      // Reset in the middle of a TLP
      rdyMode = 0;
      for (int i = 0; i < 50; i++) stageWord(4'b1101, 0);
      applyStimulus(0);
      t1 = -1;
      for (int i = 0; i < 20 && t1 < 0; i++) begin
         @(negedge clk);
         if (tx_valid) t1 = cyc;
      end
      checkOutput("midtlp_valid_seen", 64'(t1 >= 0), 64'd1);
      #2 sys_rst = 1'b1;
      #1;
      checkOutput("midrst_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("midrst_tx_data", tx_data, 64'd0);
      checkOutput("midrst_tx_flags", 64'({tx_be, tx_last, tx_err, tx_src}), 64'd0);
      checkOutput("midrst_rd_en", 64'({ch1_rd_en, ch0_rd_en}), 64'd0);
      checkOutput("midrst_counts", 64'({tlp_count0, tlp_count1, err_count}), 64'd0);
      flushReq = 1'b1;
      exp0.delete();
      exp1.delete();
      mTlp[0]   = 0;
      mTlp[1]   = 0;
      mErr      = 0;
      mInTlp[0] = 1'b0;
      mInTlp[1] = 1'b0;
      mDrain[0] = 1'b0;
      mDrain[1] = 1'b0;
      @(posedge clk);
      #3 flushReq = 1'b0;
      @(negedge clk);
      #2 sys_rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("post_rst_idle", 64'(tx_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
